// File: rtl/sata_prim_pkg.sv
// SATA primitive constants and the ALIGN-inserter state type, shared by the TX path.
package sata_prim_pkg;

  `include "sata_wrapper_define.svh"

  localparam logic [31:0] ALIGN_P  = 32'h7B4A_4ABC;
  localparam logic [31:0] SYNC_P   = 32'hB5B5_957C;
  localparam logic [3:0]  PRIM_ISK = 4'b0001;

  // One-hot encoding kept from the legacy design.
  typedef enum logic [2:0] {
    ST_NRDY = 3'b001,
    ST_INS  = 3'b010,
    ST_PASS = 3'b100
  } align_state_t;

  function automatic sata_dword_t prim_dword(input logic [31:0] p);
    sata_dword_t w;
    w.dat = p;
    w.isk = PRIM_ISK;
    return w;
  endfunction

endpackage

// File: rtl/sata_link_align_ins_if.sv
// Link-TX-mux to PHY dword stream through the ALIGN inserter, plus arbiter hint.
interface sata_link_align_ins_if;
  logic [31:0] s_dat;
  logic [3:0]  s_isk;
  logic        s_vld;
  logic        s_rdy;
  logic        m_rdy;
  logic [31:0] m_dat;
  logic [3:0]  m_isk;
  logic        roll_insert;

  // master: link layer / PHY side; slave: the inserter itself
  modport master (
    output s_dat, s_isk, s_vld, m_rdy,
    input  s_rdy, m_dat, m_isk, roll_insert
  );

  modport slave (
    input  s_dat, s_isk, s_vld, m_rdy,
    output s_rdy, m_dat, m_isk, roll_insert
  );
endinterface

// File: rtl/sata_wrapper_define.svh
// Shared SATA wrapper types: one transmitted dword with its K-character flags.
`ifndef SATA_WRAPPER_DEFINE_SVH
`define SATA_WRAPPER_DEFINE_SVH

typedef struct packed {
  logic [3:0]  isk;
  logic [31:0] dat;
} sata_dword_t;

`endif

// File: rtl/sata_link_align_ins.sv
// TX ALIGN scheduler: ALIGN_NUM ALIGNs every ALIGN_PERIOD dwords, back-pressure and roll_insert.
// Optional SATA_ALIGN_STAT_EN adds an ALIGN-pair counter (align_pair_cnt, stat_clr).
module sata_link_align_ins
  import sata_prim_pkg::*;
#(
  parameter int unsigned ALIGN_PERIOD = 256,
  parameter int unsigned ALIGN_NUM    = 2,
  parameter int unsigned PRE_WARN     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  phyrdy,
  sata_link_align_ins_if.slave  bus
`ifdef SATA_ALIGN_STAT_EN
  ,
  input  logic                  stat_clr,
  output logic [15:0]           align_pair_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(ALIGN_PERIOD);
  localparam int unsigned INS_W = $clog2(ALIGN_NUM + 1);

  localparam logic [CNT_W-1:0] CNT_WRAP = CNT_W'(ALIGN_PERIOD - ALIGN_NUM - 1);
  localparam logic [CNT_W-1:0] CNT_WARN = CNT_W'(ALIGN_PERIOD - ALIGN_NUM - PRE_WARN);
  localparam logic [INS_W-1:0] INS_LAST = INS_W'(ALIGN_NUM - 1);

  align_state_t     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [INS_W-1:0] ins_cnt_q;
  sata_dword_t      out_q;
  sata_dword_t      nxt_word;
  logic             beat;
  logic             in_pass;

  assign beat    = bus.m_rdy;
  assign in_pass = (state_q == ST_PASS);

  // A PASS beat with phyrdy low is an abort: nothing is accepted, so send ALIGN.
  always_comb begin
    nxt_word = prim_dword(ALIGN_P);
    if (in_pass && phyrdy) begin
      if (bus.s_vld) begin
        nxt_word.dat = bus.s_dat;
        nxt_word.isk = bus.s_isk;
      end else begin
        nxt_word = prim_dword(SYNC_P);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_NRDY;
      cnt_q     <= '0;
      ins_cnt_q <= '0;
      out_q     <= prim_dword(ALIGN_P);
    end else begin
      if (beat) begin
        out_q <= nxt_word;
      end
      if (!phyrdy) begin
        state_q   <= ST_NRDY;
        cnt_q     <= '0;
        ins_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_NRDY: begin
            state_q   <= ST_INS;
            cnt_q     <= '0;
            ins_cnt_q <= '0;
          end
          ST_INS: begin
            if (beat) begin
              if (ins_cnt_q == INS_LAST) begin
                ins_cnt_q <= '0;
                state_q   <= ST_PASS;
              end else begin
                ins_cnt_q <= ins_cnt_q + INS_W'(1);
              end
            end
          end
          ST_PASS: begin
            if (beat) begin
              if (cnt_q == CNT_WRAP) begin
                cnt_q   <= '0;
                state_q <= ST_INS;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          default: begin
            state_q   <= ST_NRDY;
            cnt_q     <= '0;
            ins_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.m_dat       = out_q.dat;
  assign bus.m_isk       = out_q.isk;
  assign bus.s_rdy       = in_pass && bus.m_rdy && phyrdy;
  assign bus.roll_insert = (state_q == ST_NRDY) || (state_q == ST_INS) ||
                           (in_pass && (cnt_q >= CNT_WARN));

`ifdef SATA_ALIGN_STAT_EN
  logic pair_done;

  assign pair_done = (state_q == ST_INS) && phyrdy && beat && (ins_cnt_q == INS_LAST);

  // Clear wins over a coincident increment; the count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_pair_cnt <= '0;
    end else if (stat_clr) begin
      align_pair_cnt <= '0;
    end else if (pair_done && (align_pair_cnt != '1)) begin
      align_pair_cnt <= align_pair_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sata_link_align_ins.sv
// Directed bench for sata_link_align_ins: cadence, SYNC fill, freeze, phyrdy abort, random beats.
module tb_sata_link_align_ins;
  import sata_prim_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic phyrdy;
  always #5 clk = ~clk;

  sata_link_align_ins_if bus ();

`ifdef SATA_ALIGN_STAT_EN
  logic        stat_clr = 1'b0;
  logic [15:0] align_pair_cnt;
`endif

  sata_link_align_ins #(
    .ALIGN_PERIOD(256),
    .ALIGN_NUM   (2),
    .PRE_WARN    (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .phyrdy(phyrdy),
    .bus   (bus)
`ifdef SATA_ALIGN_STAT_EN
    ,
    .stat_clr      (stat_clr),
    .align_pair_cnt(align_pair_cnt)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int unsigned cur_n = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int unsigned n);
    return 32'hD000_0000 + n;
  endfunction

  function automatic logic [3:0] isk_of(input int unsigned n);
    return 4'((n % 3) << 1);
  endfunction

  task automatic drive_src();
    bus.s_dat = word_of(cur_n);
    bus.s_isk = isk_of(cur_n);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    phyrdy     = 1'b0;
    bus.m_rdy  = 1'b1;
    bus.s_vld  = 1'b0;
    cur_n      = 0;
    drive_src();
    repeat (3) @(negedge clk);
    check_eq("rst m_dat", {bus.m_isk, bus.m_dat}, {PRIM_ISK, ALIGN_P});
    check_eq("rst s_rdy", bus.s_rdy, 1'b0);
    check_eq("rst roll", bus.roll_insert, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic link_up();
    phyrdy    = 1'b1;
    bus.m_rdy = 1'b1;
    @(negedge clk);
  endtask

  // Beat k of a window-aligned stream: positions 0/1 are ALIGN, 2..255 are PASS slots.
  task automatic run_cadence(input int k0, input int nbeats, input int gap_lo, input int gap_hi,
                             input string tag);
    int unsigned exp_n;
    exp_n = cur_n;
    for (int k = k0; k < k0 + nbeats; k++) begin
      int  p;
      int  p1;
      bit  in_pass;
      bit  gap;
      bit  acc;
      p       = k % 256;
      p1      = (k + 1) % 256;
      in_pass = (p >= 2);
      gap     = in_pass && ((p - 2) >= gap_lo) && ((p - 2) <= gap_hi);
      bus.m_rdy = 1'b1;
      bus.s_vld = !gap;
      drive_src();
      #1;
      check_eq($sformatf("%s s_rdy k=%0d", tag, k), bus.s_rdy, in_pass);
      acc = bus.s_vld && bus.s_rdy;
      @(negedge clk);
      if (acc) cur_n++;
      if (!in_pass) begin
        check_eq($sformatf("%s align k=%0d", tag, k), {bus.m_isk, bus.m_dat}, {PRIM_ISK, ALIGN_P});
      end else if (gap) begin
        check_eq($sformatf("%s sync k=%0d", tag, k), {bus.m_isk, bus.m_dat}, {PRIM_ISK, SYNC_P});
      end else begin
        check_eq($sformatf("%s data k=%0d", tag, k), {bus.m_isk, bus.m_dat},
                 {isk_of(exp_n), word_of(exp_n)});
        exp_n++;
      end
      check_eq($sformatf("%s roll k=%0d", tag, k), bus.roll_insert,
               (p1 < 2) || (p1 >= 254));
    end
  endtask

  task automatic freeze(input int ncyc, input bit exp_roll, input string tag);
    logic [35:0] held;
    held = {isk_of(cur_n - 1), word_of(cur_n - 1)};
    for (int i = 0; i < ncyc; i++) begin
      bus.m_rdy = 1'b0;
      bus.s_vld = 1'b1;
      drive_src();
      #1;
      check_eq($sformatf("%s s_rdy %0d", tag, i), bus.s_rdy, 1'b0);
      @(negedge clk);
      check_eq($sformatf("%s hold %0d", tag, i), {bus.m_isk, bus.m_dat}, held);
      check_eq($sformatf("%s roll %0d", tag, i), bus.roll_insert, exp_roll);
    end
  endtask

  task automatic run_random();
    logic [35:0] sb[$];
    logic [35:0] prev;
    logic [35:0] got;
    int  beats;
    int  aligns;
    bit  mr;
    bit  acc;
    beats  = 0;
    aligns = 0;
    mr     = 1'b1;
    prev   = {bus.m_isk, bus.m_dat};
    while (beats < 2048) begin
      bus.m_rdy = mr;
      if (!bus.s_vld) bus.s_vld = 1'($urandom_range(0, 1));
      drive_src();
      #1;
      acc = bus.s_vld && bus.s_rdy;
      if (acc) sb.push_back({bus.s_isk, bus.s_dat});
      @(negedge clk);
      got = {bus.m_isk, bus.m_dat};
      if (mr) begin
        beats++;
        if (acc) begin
          check_eq("rnd data", got, sb.pop_front());
          cur_n++;
          bus.s_vld = 1'b0;
        end else begin
          check_eq("rnd prim", ((got[31:0] == ALIGN_P) || (got[31:0] == SYNC_P)) &&
                   (got[35:32] == PRIM_ISK), 1'b1);
          if (got[31:0] == ALIGN_P) aligns++;
        end
      end else begin
        check_eq("rnd hold", got, prev);
      end
      prev = got;
      mr   = !mr;
    end
    check_eq("rnd align count", aligns, 16);
    check_eq("rnd sb empty", sb.size(), 0);
  endtask

  initial begin
    // Steady cadence with a source that is always valid (includes wrap-beat accept).
    do_reset();
    link_up();
    run_cadence(0, 520, -1, -1, "cad");

    // SYNC filler on PASS slots 10..19, cadence unaffected.
    do_reset();
    link_up();
    run_cadence(0, 520, 10, 19, "gap");

    // Freeze mid-window, abort on phyrdy drop at cnt=100, restart, freeze inside warn zone.
    do_reset();
    link_up();
    run_cadence(0, 102, -1, -1, "pre");
    freeze(20, 1'b0, "frz lo");
    bus.m_rdy = 1'b1;
    bus.s_vld = 1'b1;
    phyrdy    = 1'b0;
    #1;
    check_eq("drop s_rdy", bus.s_rdy, 1'b0);
    @(negedge clk);
    check_eq("drop m_dat", {bus.m_isk, bus.m_dat}, {PRIM_ISK, ALIGN_P});
    check_eq("drop roll", bus.roll_insert, 1'b1);
    check_eq("drop s_rdy2", bus.s_rdy, 1'b0);
    check_eq("drop words", cur_n, 100);
    link_up();
    run_cadence(0, 254, -1, -1, "rtn");
    freeze(20, 1'b1, "frz hi");
    run_cadence(254, 6, -1, -1, "post");

    // Random source with m_rdy toggling every cycle, scoreboarded.
    do_reset();
    link_up();
    run_random();

`ifdef SATA_ALIGN_STAT_EN
    do_reset();
    link_up();
    run_cadence(0, 770, -1, -1, "st");
    check_eq("stat 3 windows", align_pair_cnt, 16'd4);
    run_cadence(770, 255, -1, -1, "st2");
    check_eq("stat pre clr", align_pair_cnt, 16'd4);
    stat_clr = 1'b1;
    run_cadence(1025, 1, -1, -1, "stclr");
    stat_clr = 1'b0;
    check_eq("stat clr wins", align_pair_cnt, 16'd0);
    run_cadence(1026, 256, -1, -1, "st3");
    check_eq("stat after clr", align_pair_cnt, 16'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
